// File: rtl/combo_entry.sv
// combo_entry: six-digit combination capture front end with a one-cycle LOAD handoff.
// Defining COMBO_ENTRY_TIMEOUT_EN adds an inactivity timeout in COLLECT.
module combo_entry #(
  parameter int MAX_DIGIT      = 9,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] DIGIT,
  input  logic       ENTER,
  input  logic       CLEAR,
  output logic [4:0] check1,
  output logic [4:0] check2,
  output logic [4:0] check3,
  output logic [4:0] check4,
  output logic [4:0] check5,
  output logic [4:0] check6,
  output logic       LOAD,
  output logic [2:0] IDX,
  output logic       ERR,
  output logic       TIMEOUT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] ISSUE   = 2'd2;
  localparam logic [4:0] MAX_D   = 5'(MAX_DIGIT);

  if (MAX_DIGIT < 0 || MAX_DIGIT > 31 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("combo_entry: illegal parameter setting");
  end

  logic [1:0] r_state;
  logic [2:0] r_idx;
  logic [4:0] r_slot [0:5];
  logic       r_load;
  logic       r_err;
  logic       w_expire;

  // Entry FSM: CLEAR and expiry beat ENTER; ISSUE always lasts exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 6; i++) r_slot[i] <= 5'd0;
    end else begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          if (CLEAR || w_expire) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            for (int i = 0; i < 6; i++) r_slot[i] <= 5'd0;
          end else if (ENTER) begin
            if (DIGIT <= MAX_D) begin
              for (int i = 0; i < 6; i++) begin
                if (r_idx == 3'(i)) r_slot[i] <= DIGIT;
              end
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'd5) begin
                r_state <= ISSUE;
                r_load  <= 1'b1;
              end else begin
                r_state <= COLLECT;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // LOAD is already committed for this cycle; CLEAR only wipes the slots.
          r_state <= IDLE;
          r_idx   <= 3'd0;
          if (CLEAR) begin
            for (int i = 0; i < 6; i++) r_slot[i] <= 5'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

`ifdef COMBO_ENTRY_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  assign w_expire = (r_state == COLLECT) && (r_cnt == TO_LAST) && !ENTER && !CLEAR;

  // Idle-cycle counter, live only while collecting and reset by any ENTER.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_state != COLLECT || ENTER || CLEAR || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One-cycle TIMEOUT pulse following expiry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
    end
  end

  assign TIMEOUT = r_timeout;
`else
  assign w_expire = 1'b0;
  assign TIMEOUT  = 1'b0;
`endif

  assign check1 = r_slot[0];
  assign check2 = r_slot[1];
  assign check3 = r_slot[2];
  assign check4 = r_slot[3];
  assign check5 = r_slot[4];
  assign check6 = r_slot[5];
  assign LOAD   = r_load;
  assign IDX    = r_idx;
  assign ERR    = r_err;

endmodule
